pll_capture_reconfig_ctrl: RTL and testbench
============================================

Name: pll_capture_reconfig_ctrl

Overview:
- Sequencer that retunes the capture PLL's output counters at run time, changing the logic-analyzer sample clock (outclk_0) and word clock (outclk_1) without reprogramming the FPGA.
- Accepts one counter configuration per request, drives the Avalon-MM management port of the PLL reconfiguration core, waits for relock, and reports done or error.
- Holds capture off for the whole reconfiguration window.
- Sits between the HPS-facing CSR block and the PLL reconfiguration core, on the system clock domain.

Parameters:
- LOCK_TIMEOUT, 65535: cycles allowed from reconfiguration-complete to stable lock before declaring error.
- SETTLE_CYCLES, 16: consecutive cycles the synchronized lock must stay high before it counts as locked.
- SYNC_STAGES, 2: synchronizer depth for pll_locked (minimum 2).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- cfg_valid  in  1  request valid
- cfg_ready  out  1  controller accepts request
- cfg_c0  in  18  outclk_0 counter word: [7:0] lo, [15:8] hi, [16] bypass, [17] odd-duty
- cfg_c1  in  18  outclk_1 counter word, same format
- busy  out  1  reconfiguration in progress
- capture_hold  out  1  capture datapath must ignore PLL clocks
- done  out  1  one-cycle success pulse
- err  out  1  one-cycle failure pulse
- err_code  out  2  0 none, 1 lock timeout, 2 lock lost while idle, 3 status fail (feature only)
- pll_locked  in  1  asynchronous PLL lock
- mgmt_address  out  6  reconfig core register address
- mgmt_write  out  1  write strobe
- mgmt_read  out  1  read strobe
- mgmt_writedata  out  32  write data
- mgmt_readdata  in  32  read data
- mgmt_waitrequest  in  1  Avalon stall

Behaviour:
- Reset values:
  - cfg_ready=1, capture_hold=1.
  - busy, done, err, mgmt_write, mgmt_read = 0; err_code=0; mgmt_address=0; mgmt_writedata=0.
  - FSM enters WAIT_LOCK, so power-up also waits for first lock.
- cfg_ready=1 only in IDLE. A transfer occurs when cfg_valid&cfg_ready; cfg_c0/cfg_c1 are latched that cycle.
- FSM: IDLE → WR_MODE → WR_C0 → WR_C1 → WR_START → WAIT_DONE → WAIT_LOCK → IDLE.
- Write states: address/data/mgmt_write are asserted the cycle after entry and held until a cycle with mgmt_waitrequest=0, then the FSM advances.
  - WR_MODE: addr 0x00, data 0 (waitrequest mode).
  - WR_C0: addr 0x05, data = {9'b0, 5'd0, c0}.
  - WR_C1: addr 0x05, data = {9'b0, 5'd1, c1}; the counter select occupies [22:18].
  - WR_START: addr 0x02, data 1.
- WAIT_DONE: advances on the first cycle mgmt_waitrequest=0 after the start write completes.
- WAIT_LOCK:
  - Counter cleared on entry; settle counter counts consecutive synced-lock-high cycles and resets to 0 on any low.
  - Reaching SETTLE_CYCLES → done pulse, capture_hold=0, go to IDLE.
  - Timeout counter reaching LOCK_TIMEOUT first → err pulse, err_code=1, capture_hold stays 1, go to IDLE.
  - At reset exit, a successful lock does not pulse done.
- busy=1 in every state except IDLE. capture_hold goes to 1 on request accept.
- IDLE lock monitor: synced lock falling while capture_hold=0 → err pulse, err_code=2, capture_hold=1, go to WAIT_LOCK (auto re-arm).
- err_code holds its last value until the next accepted request, which clears it to 0.
- Mid-operation reset: all outputs and counters return to reset values immediately. Any in-flight Avalon write is abandoned and the reconfig core is reset externally by the same rst.
- cfg_valid while busy is ignored (not queued).
- Latency (no waitrequest stalls): done no earlier than 4 writes + WAIT_DONE + SETTLE_CYCLES + SYNC_STAGES cycles after accept.

Optional Feature:
- Macro: PLL_RECFG_STATUS_CHECK_EN.
- With the macro: after WAIT_DONE, state RD_STATUS issues a read of addr 0x01 (mgmt_read held until waitrequest=0). readdata[0]=1 → WAIT_LOCK; 0 → err pulse, err_code=3, IDLE.
- Without the macro: no RD_STATUS state, mgmt_read is tied 0, and err_code value 3 never occurs.

Decomposition:
- Shared package pll_recfg_pkg:
  - Register address constants (MODE=0x00, STATUS=0x01, START=0x02, C_CNT=0x05).
  - FSM state enum.
  - err_code enum.
  - Counter-word field offsets (LO=0, HI=8, BYPASS=16, ODD=17, SEL=18).
- One sub-module, pll_lock_monitor: synchronizer, settle counter, lock-fall detect. Its outputs are locked_stable and lock_fell.

Test Plan:
- Reset, pll_locked rises at cycle 10 and stays high → capture_hold falls SYNC_STAGES+16 cycles later; no done pulse; busy=0.
- Request c0=0x10101, c1=0x00107, waitrequest 0, locked dips for 20 cycles after start → write sequence (0x00,0x0), (0x05,0x10101), (0x05,0x40107), (0x02,0x1); then done pulse, err_code=0.
- Same request with waitrequest held high 5 cycles on each write → each write held stable 6 cycles, data unchanged, order preserved.
- Lock never returns with LOCK_TIMEOUT=100 → err pulse 100 cycles into WAIT_LOCK, err_code=1, capture_hold=1, cfg_ready=1.
- In IDLE, lock drops for 3 cycles → err_code=2, capture_hold=1; after relock +16 cycles → capture_hold=0 with no done pulse.
- rst asserted during WR_C1 stall → mgmt_write=0 and cfg_ready=1 immediately. With PLL_RECFG_STATUS_CHECK_EN and readdata=0 → err_code=3.

Source files
------------

// File: rtl/pll_recfg_pkg.sv
// Shared constants, state encoding and counter-word packing for the capture PLL
// reconfiguration sequencer.
package pll_recfg_pkg;

  localparam logic [5:0] ADDR_MODE   = 6'h00;
  localparam logic [5:0] ADDR_STATUS = 6'h01;
  localparam logic [5:0] ADDR_START  = 6'h02;
  localparam logic [5:0] ADDR_C_CNT  = 6'h05;

  localparam int OFS_LO     = 0;
  localparam int OFS_HI     = 8;
  localparam int OFS_BYPASS = 16;
  localparam int OFS_ODD    = 17;
  localparam int OFS_SEL    = 18;

  typedef logic [3:0] state_t;
  localparam state_t ST_IDLE      = 4'd0;
  localparam state_t ST_WR_MODE   = 4'd1;
  localparam state_t ST_WR_C0     = 4'd2;
  localparam state_t ST_WR_C1     = 4'd3;
  localparam state_t ST_WR_START  = 4'd4;
  localparam state_t ST_WAIT_DONE = 4'd5;
  localparam state_t ST_WAIT_LOCK = 4'd6;
  localparam state_t ST_RD_STATUS = 4'd7;

  typedef enum logic [1:0] {
    ERR_NONE      = 2'd0,
    ERR_TIMEOUT   = 2'd1,
    ERR_LOCK_LOST = 2'd2,
    ERR_STATUS    = 2'd3
  } err_code_t;

  // Builds the C-counter register word: counter select above the 18-bit setting.
  function automatic logic [31:0] cnt_word(input logic [4:0] sel, input logic [17:0] cfg);
    logic [31:0] w;
    w = 32'd0;
    w[OFS_LO +: 8]    = cfg[OFS_LO +: 8];
    w[OFS_HI +: 8]    = cfg[OFS_HI +: 8];
    w[OFS_BYPASS]     = cfg[OFS_BYPASS];
    w[OFS_ODD]        = cfg[OFS_ODD];
    w[OFS_SEL +: 5]   = sel;
    return w;
  endfunction

endpackage

// File: rtl/pll_lock_monitor.sv
// Synchronizes the asynchronous PLL lock, qualifies it with a settle counter and
// flags a falling edge of the synchronized lock.
module pll_lock_monitor #(
  parameter int SETTLE_CYCLES = 16,
  parameter int SYNC_STAGES   = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clear,
  input  logic i_lock_async,
  output logic o_locked_stable,
  output logic o_lock_fell
);

  localparam int CNT_W = $clog2(SETTLE_CYCLES + 1);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_sync_prev;
  logic [CNT_W-1:0]       r_settle_cnt;
  logic                   w_synced;

  assign w_synced = r_sync[SYNC_STAGES-1];

  // Lock synchronizer chain and one-cycle history for edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync      <= '0;
      r_sync_prev <= 1'b0;
    end else begin
      r_sync      <= {r_sync[SYNC_STAGES-2:0], i_lock_async};
      r_sync_prev <= w_synced;
    end
  end

  // Consecutive-high counter; any low sample or a clear restarts qualification.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_settle_cnt <= '0;
    end else if (i_clear || !w_synced) begin
      r_settle_cnt <= '0;
    end else if (r_settle_cnt != CNT_W'(SETTLE_CYCLES)) begin
      r_settle_cnt <= r_settle_cnt + CNT_W'(1);
    end else begin
      r_settle_cnt <= r_settle_cnt;
    end
  end

  assign o_locked_stable = w_synced && (r_settle_cnt == CNT_W'(SETTLE_CYCLES));
  assign o_lock_fell     = r_sync_prev && !w_synced;

endmodule

// File: rtl/pll_capture_reconfig_ctrl.sv
// Capture PLL counter retune sequencer driving the reconfig core's Avalon-MM port.
// Optional readback of the reconfig status register: PLL_RECFG_STATUS_CHECK_EN.
module pll_capture_reconfig_ctrl
  import pll_recfg_pkg::*;
#(
  parameter int LOCK_TIMEOUT  = 65535,
  parameter int SETTLE_CYCLES = 16,
  parameter int SYNC_STAGES   = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cfg_valid,
  output logic        cfg_ready,
  input  logic [17:0] cfg_c0,
  input  logic [17:0] cfg_c1,
  output logic        busy,
  output logic        capture_hold,
  output logic        done,
  output logic        err,
  output logic [1:0]  err_code,
  input  logic        pll_locked,
  output logic [5:0]  mgmt_address,
  output logic        mgmt_write,
  output logic        mgmt_read,
  output logic [31:0] mgmt_writedata,
  input  logic [31:0] mgmt_readdata,
  input  logic        mgmt_waitrequest
);

  localparam int TMO_W = $clog2(LOCK_TIMEOUT + 1);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [17:0]       r_c0;
  logic [17:0]       r_c1;
  logic [TMO_W-1:0]  r_tmo_cnt;
  logic              r_req_active;
  logic              r_cfg_ready;
  logic              r_busy;
  logic              r_capture_hold;
  logic              r_done;
  logic              r_err;
  err_code_t         r_err_code;
  logic [5:0]        r_mgmt_address;
  logic              r_mgmt_write;
  logic [31:0]       r_mgmt_writedata;

  logic              w_accept;
  logic              w_wr_done;
  logic              w_tmo_hit;
  logic              w_locked_stable;
  logic              w_lock_fell;
  logic              w_done;
  logic              w_err;
  err_code_t         w_err_code_nxt;
  logic              w_hold_nxt;
  logic [5:0]        w_addr_nxt;
  logic [31:0]       w_data_nxt;
  logic              w_write_nxt;
  logic              w_read_nxt;
  logic              w_unused;

  assign w_unused = ^mgmt_readdata;

  // Only possible in IDLE, or in the first cycle after reset while cfg_ready still shows its reset value.
  assign w_accept  = cfg_valid && r_cfg_ready;
  assign w_wr_done = r_mgmt_write && !mgmt_waitrequest;
  assign w_tmo_hit = (r_tmo_cnt == TMO_W'(LOCK_TIMEOUT - 1));

  pll_lock_monitor #(
    .SETTLE_CYCLES (SETTLE_CYCLES),
    .SYNC_STAGES   (SYNC_STAGES)
  ) u_lock_monitor (
    .clk             (clk),
    .rst             (rst),
    .i_clear         (r_state != ST_WAIT_LOCK),
    .i_lock_async    (pll_locked),
    .o_locked_stable (w_locked_stable),
    .o_lock_fell     (w_lock_fell)
  );

  // Next-state, completion pulses, error code and capture hold decisions.
  always_comb begin
    w_state_nxt    = r_state;
    w_done         = 1'b0;
    w_err          = 1'b0;
    w_err_code_nxt = r_err_code;
    w_hold_nxt     = r_capture_hold;
    if (w_accept) begin
      w_state_nxt    = ST_WR_MODE;
      w_err_code_nxt = ERR_NONE;
      w_hold_nxt     = 1'b1;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_lock_fell && !r_capture_hold) begin
            w_state_nxt    = ST_WAIT_LOCK;
            w_err          = 1'b1;
            w_err_code_nxt = ERR_LOCK_LOST;
            w_hold_nxt     = 1'b1;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end
        ST_WR_MODE:  w_state_nxt = w_wr_done ? ST_WR_C0 : ST_WR_MODE;
        ST_WR_C0:    w_state_nxt = w_wr_done ? ST_WR_C1 : ST_WR_C0;
        ST_WR_C1:    w_state_nxt = w_wr_done ? ST_WR_START : ST_WR_C1;
        ST_WR_START: w_state_nxt = w_wr_done ? ST_WAIT_DONE : ST_WR_START;
        ST_WAIT_DONE: begin
          if (!mgmt_waitrequest) begin
`ifdef PLL_RECFG_STATUS_CHECK_EN
            w_state_nxt = ST_RD_STATUS;
`else
            w_state_nxt = ST_WAIT_LOCK;
`endif
          end else begin
            w_state_nxt = ST_WAIT_DONE;
          end
        end
`ifdef PLL_RECFG_STATUS_CHECK_EN
        ST_RD_STATUS: begin
          if (!mgmt_waitrequest && mgmt_readdata[0]) begin
            w_state_nxt = ST_WAIT_LOCK;
          end else if (!mgmt_waitrequest) begin
            w_state_nxt    = ST_IDLE;
            w_err          = 1'b1;
            w_err_code_nxt = ERR_STATUS;
          end else begin
            w_state_nxt = ST_RD_STATUS;
          end
        end
`endif
        ST_WAIT_LOCK: begin
          if (w_locked_stable) begin
            w_state_nxt = ST_IDLE;
            w_done      = r_req_active;
            w_hold_nxt  = 1'b0;
          end else if (w_tmo_hit) begin
            w_state_nxt    = ST_IDLE;
            w_err          = 1'b1;
            w_err_code_nxt = ERR_TIMEOUT;
          end else begin
            w_state_nxt = ST_WAIT_LOCK;
          end
        end
        default: begin
          w_state_nxt = ST_IDLE;
          w_hold_nxt  = 1'b1;
        end
      endcase
    end
  end

  // Avalon command for the state about to be occupied, so it stays stable through stalls.
  always_comb begin
    w_addr_nxt  = 6'h00;
    w_data_nxt  = 32'd0;
    w_write_nxt = 1'b0;
    w_read_nxt  = 1'b0;
    case (w_state_nxt)
      ST_WR_MODE: begin
        w_addr_nxt  = ADDR_MODE;
        w_write_nxt = 1'b1;
      end
      ST_WR_C0: begin
        w_addr_nxt  = ADDR_C_CNT;
        w_data_nxt  = cnt_word(5'd0, r_c0);
        w_write_nxt = 1'b1;
      end
      ST_WR_C1: begin
        w_addr_nxt  = ADDR_C_CNT;
        w_data_nxt  = cnt_word(5'd1, r_c1);
        w_write_nxt = 1'b1;
      end
      ST_WR_START: begin
        w_addr_nxt  = ADDR_START;
        w_data_nxt  = 32'd1;
        w_write_nxt = 1'b1;
      end
      ST_RD_STATUS: begin
        w_addr_nxt = ADDR_STATUS;
        w_read_nxt = 1'b1;
      end
      default: begin
        w_addr_nxt = 6'h00;
      end
    endcase
  end

  // FSM state, request latch, lock timeout counter and all registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state          <= ST_WAIT_LOCK;
      r_c0             <= 18'd0;
      r_c1             <= 18'd0;
      r_tmo_cnt        <= '0;
      r_req_active     <= 1'b0;
      r_cfg_ready      <= 1'b1;
      r_busy           <= 1'b0;
      r_capture_hold   <= 1'b1;
      r_done           <= 1'b0;
      r_err            <= 1'b0;
      r_err_code       <= ERR_NONE;
      r_mgmt_address   <= 6'h00;
      r_mgmt_write     <= 1'b0;
      r_mgmt_writedata <= 32'd0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_c0 <= cfg_c0;
        r_c1 <= cfg_c1;
      end
      r_tmo_cnt        <= (r_state == ST_WAIT_LOCK) ? r_tmo_cnt + TMO_W'(1) : '0;
      r_req_active     <= w_accept || (r_req_active && (w_state_nxt != ST_IDLE));
      r_cfg_ready      <= (w_state_nxt == ST_IDLE);
      r_busy           <= (w_state_nxt != ST_IDLE);
      r_capture_hold   <= w_hold_nxt;
      r_done           <= w_done;
      r_err            <= w_err;
      r_err_code       <= w_err_code_nxt;
      r_mgmt_address   <= w_addr_nxt;
      r_mgmt_write     <= w_write_nxt;
      r_mgmt_writedata <= w_data_nxt;
    end
  end

`ifdef PLL_RECFG_STATUS_CHECK_EN
  logic r_mgmt_read;

  // Status read strobe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mgmt_read <= 1'b0;
    end else begin
      r_mgmt_read <= w_read_nxt;
    end
  end

  assign mgmt_read = r_mgmt_read;
`else
  logic w_unused_read;
  assign w_unused_read = w_read_nxt;
  assign mgmt_read     = 1'b0;
`endif

  assign cfg_ready      = r_cfg_ready;
  assign busy           = r_busy;
  assign capture_hold   = r_capture_hold;
  assign done           = r_done;
  assign err            = r_err;
  assign err_code       = r_err_code;
  assign mgmt_address   = r_mgmt_address;
  assign mgmt_write     = r_mgmt_write;
  assign mgmt_writedata = r_mgmt_writedata;

endmodule

// File: tb/tb_pll_capture_reconfig_ctrl.sv
// Self-checking bench: Avalon slave with programmable stalls, lock stimulus and a
// request-level reference of the write sequence, lock timing and error codes.
module tb_pll_capture_reconfig_ctrl;

  localparam int LOCK_TIMEOUT = 100;
  localparam int SETTLE       = 16;
  localparam int SYNC         = 2;
`ifdef PLL_RECFG_STATUS_CHECK_EN
  localparam int POST_START   = 3;
`else
  localparam int POST_START   = 2;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cfg_valid = 1'b0;
  logic [17:0] cfg_c0 = 18'd0;
  logic [17:0] cfg_c1 = 18'd0;
  logic        pll_locked = 1'b0;
  logic [31:0] status_rd = 32'd1;
  logic        waitreq = 1'b0;
  logic        cfg_ready, busy, capture_hold, done, err, mgmt_write, mgmt_read;
  logic [1:0]  err_code;
  logic [5:0]  mgmt_address;
  logic [31:0] mgmt_writedata;

  pll_capture_reconfig_ctrl #(
    .LOCK_TIMEOUT (LOCK_TIMEOUT),
    .SETTLE_CYCLES(SETTLE),
    .SYNC_STAGES  (SYNC)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .cfg_valid        (cfg_valid),
    .cfg_ready        (cfg_ready),
    .cfg_c0           (cfg_c0),
    .cfg_c1           (cfg_c1),
    .busy             (busy),
    .capture_hold     (capture_hold),
    .done             (done),
    .err              (err),
    .err_code         (err_code),
    .pll_locked       (pll_locked),
    .mgmt_address     (mgmt_address),
    .mgmt_write       (mgmt_write),
    .mgmt_read        (mgmt_read),
    .mgmt_writedata   (mgmt_writedata),
    .mgmt_readdata    (status_rd),
    .mgmt_waitrequest (waitreq)
  );

  always #5 clk = ~clk;

  int          n_assert = 0;
  int          n_fail   = 0;
  int          cyc = 0;
  int          stall_n = 0;
  int          wcnt = 0;
  logic [5:0]  q_addr[$];
  logic [31:0] q_data[$];
  int          q_held[$];
  bit          q_stable[$];
  int          q_cyc[$];
  int          done_cnt = 0, err_cnt = 0, last_done_cyc = 0, last_err_cyc = 0;
  logic [1:0]  last_err_code = 2'd0;
  bit          pulse_wide = 1'b0, saw_read = 1'b0, saw_code3 = 1'b0;
  logic        prev_done = 1'b0, prev_err = 1'b0;
  logic [5:0]  cur_a = 6'd0;
  logic [31:0] cur_d = 32'd0;
  bit          cur_stable = 1'b1;

  // Avalon slave model and event recorder, evaluated on the falling edge.
  always @(negedge clk) begin
    cyc = cyc + 1;
    if (done) begin done_cnt = done_cnt + 1; last_done_cyc = cyc; end
    if (err)  begin err_cnt = err_cnt + 1; last_err_cyc = cyc; last_err_code = err_code; end
    if ((done && prev_done) || (err && prev_err)) pulse_wide = 1'b1;
    prev_done = done;
    prev_err  = err;
    if (mgmt_read) saw_read = 1'b1;
    if (err_code == 2'd3) saw_code3 = 1'b1;
    if (rst) begin
      waitreq = 1'b0;
      wcnt    = 0;
    end else if (mgmt_write || mgmt_read) begin
      if (wcnt == 0) begin
        cur_a = mgmt_address; cur_d = mgmt_writedata; cur_stable = 1'b1;
      end else if (mgmt_address !== cur_a || mgmt_writedata !== cur_d) begin
        cur_stable = 1'b0;
      end
      if (wcnt < stall_n) begin
        waitreq = 1'b1;
        wcnt    = wcnt + 1;
      end else begin
        if (mgmt_write) begin
          q_addr.push_back(mgmt_address); q_data.push_back(mgmt_writedata);
          q_held.push_back(wcnt + 1); q_stable.push_back(cur_stable); q_cyc.push_back(cyc);
        end
        waitreq = 1'b0;
        wcnt    = 0;
      end
    end else begin
      waitreq = 1'b0;
      wcnt    = 0;
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_rng(input string tag, input int v, input int lo, input int hi);
    n_assert++;
    assert (v >= lo && v <= hi) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d..%0d", tag, v, lo, hi);
    end
  endtask

  // One request; dip > 0 drops lock that many cycles after the start write, dip < 0 never relocks.
  task automatic do_req(input logic [17:0] c0, input logic [17:0] c1, input int stall, input int dip);
    logic [5:0]  exp_a[4];
    logic [31:0] exp_d[4];
    int d0, e0, acc, rise;
    exp_a[0] = 6'h00; exp_d[0] = 32'h0;
    exp_a[1] = 6'h05; exp_d[1] = 32'(c0);
    exp_a[2] = 6'h05; exp_d[2] = 32'(c1) + (32'd1 << 18);
    exp_a[3] = 6'h02; exp_d[3] = 32'h1;
    stall_n = stall;
    q_addr.delete(); q_data.delete(); q_held.delete(); q_stable.delete(); q_cyc.delete();
    d0 = done_cnt; e0 = err_cnt; rise = 0;
    cfg_c0 = c0; cfg_c1 = c1; cfg_valid = 1'b1;
    tick();
    cfg_valid = 1'b0;
    acc = cyc;
    chk("accept_busy", busy, 1'b1);
    chk("accept_ready", cfg_ready, 1'b0);
    chk("accept_hold", capture_hold, 1'b1);
    chk("accept_errcode_clr", err_code, 2'd0);
    for (int n = 0; n < 200 && q_addr.size() < 4; n++) tick();
    chk("write_count", q_addr.size(), 4);
    if (dip > 0) begin
      pll_locked = 1'b0;
      repeat (dip) tick();
      pll_locked = 1'b1;
      rise = cyc;
    end else begin
      pll_locked = 1'b0;
    end
    for (int n = 0; n < LOCK_TIMEOUT + 200 && done_cnt == d0 && err_cnt == e0; n++) tick();
    for (int i = 0; i < 4 && i < q_addr.size(); i++) begin
      chk($sformatf("wr%0d_addr", i), q_addr[i], exp_a[i]);
      chk($sformatf("wr%0d_data", i), q_data[i], exp_d[i]);
      chk($sformatf("wr%0d_held", i), q_held[i], stall + 1);
      chk($sformatf("wr%0d_stable", i), q_stable[i], 1'b1);
    end
    if (dip > 0) begin
      chk("done_pulse", done_cnt - d0, 1);
      chk("no_err", err_cnt - e0, 0);
      chk("done_errcode", err_code, 2'd0);
      chk("done_hold", capture_hold, 1'b0);
      chk("done_ready", cfg_ready, 1'b1);
      chk("done_busy", busy, 1'b0);
      chk_rng("done_after_relock", last_done_cyc - rise, SYNC + SETTLE, SYNC + SETTLE + 2);
      chk_rng("done_after_accept", last_done_cyc - acc, 4 + 1 + SETTLE + SYNC, 100000);
    end else begin
      chk("tmo_err_pulse", err_cnt - e0, 1);
      chk("tmo_no_done", done_cnt - d0, 0);
      chk("tmo_errcode", last_err_code, 2'd1);
      chk("tmo_hold", capture_hold, 1'b1);
      chk("tmo_ready", cfg_ready, 1'b1);
      chk("tmo_busy", busy, 1'b0);
      if (q_cyc.size() == 4) chk("tmo_cycle", last_err_cyc - q_cyc[3], POST_START + LOCK_TIMEOUT);
      pll_locked = 1'b1;
    end
    tick();
    chk("pulse_dropped", {done, err}, 2'b00);
  endtask

  initial begin
    int d0, e0, rise;
    bit found;
    repeat (3) tick();
    chk("rst_ready", cfg_ready, 1'b1);
    chk("rst_hold", capture_hold, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done_err", {done, err}, 2'b00);
    chk("rst_wr_rd", {mgmt_write, mgmt_read}, 2'b00);
    chk("rst_errcode", err_code, 2'd0);
    chk("rst_addr", mgmt_address, 6'h00);
    chk("rst_wdata", mgmt_writedata, 32'h0);
    rst = 1'b0;

    // Power-up: first lock releases capture without a done pulse.
    repeat (10) tick();
    pll_locked = 1'b1;
    rise = cyc;
    for (int n = 0; n < 100 && capture_hold; n++) tick();
    chk_rng("pwrup_release", cyc - rise, SYNC + SETTLE, SYNC + SETTLE + 2);
    chk("pwrup_no_done", done_cnt, 0);
    chk("pwrup_no_err", err_cnt, 0);
    chk("pwrup_busy", busy, 1'b0);
    chk("pwrup_ready", cfg_ready, 1'b1);

    do_req(18'h10101, 18'h00107, 0, 20);
    do_req(18'h10101, 18'h00107, 5, 20);
    do_req(18'h2A5C3, 18'h1F00E, 0, -1);
    do_req(18'h0FFFF, 18'h30001, 2, 25);

    // Lock lost while idle and released: auto re-arm, no done.
    d0 = done_cnt; e0 = err_cnt;
    pll_locked = 1'b0;
    repeat (3) tick();
    pll_locked = 1'b1;
    for (int n = 0; n < 30 && err_cnt == e0; n++) tick();
    chk("lost_err_pulse", err_cnt - e0, 1);
    chk("lost_errcode_pulse", last_err_code, 2'd2);
    chk("lost_errcode", err_code, 2'd2);
    chk("lost_hold", capture_hold, 1'b1);
    for (int n = 0; n < 80 && capture_hold; n++) tick();
    chk("lost_rearm_hold", capture_hold, 1'b0);
    chk("lost_no_done", done_cnt - d0, 0);
    chk("lost_errcode_kept", err_code, 2'd2);

    for (int k = 0; k < 3; k++)
      do_req(18'($urandom), 18'($urandom), int'($urandom_range(0, 5)), int'($urandom_range(12, 30)));

    // Reset while the second counter write is stalled.
    d0 = done_cnt;
    stall_n = 50;
    cfg_c0 = 18'h01234; cfg_c1 = 18'h04321; cfg_valid = 1'b1;
    tick();
    cfg_valid = 1'b0;
    found = 1'b0;
    for (int n = 0; n < 300 && !found; n++) begin
      tick();
      found = mgmt_write && mgmt_address == 6'h05 && mgmt_writedata[22:18] == 5'd1;
    end
    chk("c1_stall_seen", found, 1'b1);
    rst = 1'b1;
    #1;
    chk("midrst_write", mgmt_write, 1'b0);
    chk("midrst_ready", cfg_ready, 1'b1);
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_hold", capture_hold, 1'b1);
    chk("midrst_addr_data", {mgmt_address, mgmt_writedata}, 38'h0);
    repeat (2) tick();
    rst = 1'b0;
    stall_n = 0;
    for (int n = 0; n < 80 && capture_hold; n++) tick();
    chk("midrst_relock", capture_hold, 1'b0);
    chk("midrst_no_done", done_cnt - d0, 0);

`ifdef PLL_RECFG_STATUS_CHECK_EN
    e0 = err_cnt;
    status_rd = 32'd0;
    cfg_c0 = 18'h00505; cfg_c1 = 18'h00303; cfg_valid = 1'b1;
    tick();
    cfg_valid = 1'b0;
    for (int n = 0; n < 100 && err_cnt == e0; n++) tick();
    chk("status_err_pulse", err_cnt - e0, 1);
    chk("status_errcode", last_err_code, 2'd3);
    chk("status_hold", capture_hold, 1'b1);
    chk("status_read_seen", saw_read, 1'b1);
    status_rd = 32'd1;
`else
    chk("no_read_strobe", saw_read, 1'b0);
    chk("no_errcode3", saw_code3, 1'b0);
`endif
    chk("single_cycle_pulses", pulse_wide, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: observed no end of test, expected finish before 1000000");
    $fatal(1);
  end

endmodule
